// File: rtl/irq_dispatch_seq_if.sv
// Bus between the SM83 decoder/IRQ logic and the interrupt dispatch sequencer.
// MCYC qualifies every input and every output update; nothing is sampled between strobes.
interface irq_dispatch_seq_if;
  // Strobe semantics: inputs are meaningful only in a CLK cycle with MCYC=1,
  // and outputs hold steady from one MCYC strobe to the next.
  logic       MCYC;
  logic [7:0] PENDING;
  logic       INSTR_DONE;
  logic       OP_EI;
  logic       OP_DI;
  logic       OP_RETI;
  logic       OP_HALT;
  logic       IME;
  logic       HALTED;
  logic       WAKE;
  logic       BUSY;
  logic       PUSH_HI;
  logic       PUSH_LO;
  logic       JUMP;
  logic [7:0] VEC;
  logic [7:0] CPU_IRQ_ACK;
  logic [2:0] DBG_STATE;

  modport master (
    output MCYC, PENDING, INSTR_DONE, OP_EI, OP_DI, OP_RETI, OP_HALT,
    input  IME, HALTED, WAKE, BUSY, PUSH_HI, PUSH_LO, JUMP, VEC, CPU_IRQ_ACK, DBG_STATE
  );

  modport slave (
    input  MCYC, PENDING, INSTR_DONE, OP_EI, OP_DI, OP_RETI, OP_HALT,
    output IME, HALTED, WAKE, BUSY, PUSH_HI, PUSH_LO, JUMP, VEC, CPU_IRQ_ACK, DBG_STATE
  );
endinterface

// File: rtl/irq_dispatch_seq.sv
// SM83 interrupt dispatch sequencer: IME/EI-delay bookkeeping, HALT wake-up and
// the WAIT..PUSH_HI..PUSH_LO..JUMP entry sequence with one-hot IF acknowledge.
module irq_dispatch_seq #(
  parameter logic [7:0]  VEC_BASE    = 8'h40,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           CLK,
  input logic           SYNC_RES,
  irq_dispatch_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_WAIT    = 3'd2,
    S_PUSH_HI = 3'd3,
    S_PUSH_LO = 3'd4,
    S_JUMP    = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       ime_q, ime_d;
  logic       ei_pend_q, ei_pend_d;
  logic [1:0] cnt_q, cnt_d;
  logic       halted_q, halted_d;
  logic       wake_q, wake_d;
  logic       busy_q, busy_d;
  logic       push_hi_q, push_hi_d;
  logic       push_lo_q, push_lo_d;
  logic       jump_q, jump_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] ack_q, ack_d;

  logic [2:0] win_k;
  logic       any_pend;
  logic       ime_eff;

  assign any_pend = |bus.PENDING;
  // Effective enable at this boundary: a pending EI matures now, RETI is immediate, DI wins.
  assign ime_eff  = (ime_q | ei_pend_q | bus.OP_RETI) & ~bus.OP_DI;

  always_comb begin
    win_k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.PENDING[i]) win_k = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    wake_d    = wake_q;
    busy_d    = busy_q;
    push_hi_d = push_hi_q;
    push_lo_d = push_lo_q;
    jump_d    = jump_q;
    vec_d     = vec_q;
    ack_d     = ack_q;
    if (bus.MCYC) begin
      halted_d  = 1'b0;
      wake_d    = 1'b0;
      busy_d    = 1'b0;
      push_hi_d = 1'b0;
      push_lo_d = 1'b0;
      jump_d    = 1'b0;
      ack_d     = 8'h00;
      unique case (state_q)
        S_IDLE: begin
          if (bus.INSTR_DONE) begin
            if (ei_pend_q) begin
              ime_d     = 1'b1;
              ei_pend_d = 1'b0;
            end
            if (bus.OP_EI)   ei_pend_d = 1'b1;
            if (bus.OP_RETI) ime_d     = 1'b1;
            if (bus.OP_DI) begin
              ime_d     = 1'b0;
              ei_pend_d = 1'b0;
            end
          end
          if (bus.INSTR_DONE && ime_eff && any_pend) begin
            state_d   = S_WAIT;
            busy_d    = 1'b1;
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
            cnt_d     = 2'(WAIT_CYCLES - 1);
          end else if (bus.OP_HALT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end
        S_HALT: begin
          if (any_pend) begin
            wake_d = 1'b1;
            if (ime_q) begin
              state_d   = S_WAIT;
              busy_d    = 1'b1;
              ime_d     = 1'b0;
              ei_pend_d = 1'b0;
              cnt_d     = 2'(WAIT_CYCLES - 1);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            halted_d = 1'b1;
          end
        end
        S_WAIT: begin
          busy_d = 1'b1;
          if (cnt_q == 2'd0) begin
            state_d   = S_PUSH_HI;
            push_hi_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        S_PUSH_HI: begin
          // Late priority decision: whatever is pending now is what gets serviced.
          state_d   = S_PUSH_LO;
          busy_d    = 1'b1;
          push_lo_d = 1'b1;
          if (any_pend) begin
            vec_d = VEC_BASE + {2'b00, win_k, 3'b000};
            ack_d = 8'd1 << win_k;
          end else begin
            vec_d = 8'h00;
          end
        end
        S_PUSH_LO: begin
          state_d = S_JUMP;
          busy_d  = 1'b1;
          jump_d  = 1'b1;
        end
        S_JUMP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      state_q   <= S_IDLE;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      cnt_q     <= 2'd0;
      halted_q  <= 1'b0;
      wake_q    <= 1'b0;
      busy_q    <= 1'b0;
      push_hi_q <= 1'b0;
      push_lo_q <= 1'b0;
      jump_q    <= 1'b0;
      vec_q     <= 8'h00;
      ack_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      wake_q    <= wake_d;
      busy_q    <= busy_d;
      push_hi_q <= push_hi_d;
      push_lo_q <= push_lo_d;
      jump_q    <= jump_d;
      vec_q     <= vec_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.IME         = ime_q;
  assign bus.HALTED      = halted_q;
  assign bus.WAKE        = wake_q;
  assign bus.BUSY        = busy_q;
  assign bus.PUSH_HI     = push_hi_q;
  assign bus.PUSH_LO     = push_lo_q;
  assign bus.JUMP        = jump_q;
  assign bus.VEC         = vec_q;
  assign bus.CPU_IRQ_ACK = ack_q;
  assign bus.DBG_STATE   = state_q;

endmodule
